// File: rtl/dcr_seq_pkg.sv
// Shared types and sizing helpers for the DC-removal sequencer.
// Used by dc_removal_seq and dcr_frame_out.
package dcr_seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        CALIB  = 3'd2,
        RUN    = 3'd3,
        ERR    = 3'd4
    } dcr_state_t;

    // Calibration gives up after two full averaging windows without an enable edge.
    function automatic int calib_timeout(input int avg_window);
        return 2 * avg_window;
    endfunction

    function automatic int cnt_width(input int terminal);
        return $clog2(terminal) + 1;
    endfunction

endpackage

// File: rtl/dcr_frame_out.sv
// Output stage: one-deep sample register with valid/ready handshake,
// frame position counter, end-of-frame flag and sticky overrun.
module dcr_frame_out
    import dcr_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int FRAME_LEN  = 256
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         clr_ovr,
    input  logic                         accept,
    input  logic signed [DATA_WIDTH:0]   in_data,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH:0]   out_data,
    output logic                         out_valid,
    output logic                         out_last,
    output logic                         overrun
);

    localparam int FRAME_W = cnt_width(FRAME_LEN - 1);

    logic signed [DATA_WIDTH:0] data_reg;
    logic                       valid_reg;
    logic                       overrun_reg;
    logic [FRAME_W-1:0]         frame_cnt_reg;
    logic                       xfer;
    logic                       room;

    assign xfer = valid_reg && out_ready;
    // A sample leaving this cycle frees the register for the one arriving.
    assign room = !valid_reg || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_reg      <= '0;
            valid_reg     <= 1'b0;
            frame_cnt_reg <= '0;
            overrun_reg   <= 1'b0;
        end else begin
            if (flush) begin
                data_reg      <= '0;
                valid_reg     <= 1'b0;
                frame_cnt_reg <= '0;
            end else begin
                if (accept && room) begin
                    data_reg  <= in_data;
                    valid_reg <= 1'b1;
                end else if (xfer) begin
                    valid_reg <= 1'b0;
                end
                if (xfer) begin
                    frame_cnt_reg <= (frame_cnt_reg == FRAME_W'(FRAME_LEN - 1))
                                     ? '0 : frame_cnt_reg + 1'b1;
                end
            end

            if (clr_ovr) begin
                overrun_reg <= 1'b0;
            end else if (accept && !room) begin
                overrun_reg <= 1'b1;
            end
        end
    end

    assign out_data  = data_reg;
    assign out_valid = valid_reg;
    assign out_last  = valid_reg && (frame_cnt_reg == FRAME_W'(FRAME_LEN - 1));
    assign overrun   = overrun_reg;

endmodule

// File: rtl/dc_removal_seq.sv
// DC-removal sequencer: settle, calibrate against the remover's enable, then stream frames.
// Define DCR_SEQ_DECIM_EN to accept only every DECIM-th remover sample in RUN.
module dc_removal_seq
    import dcr_seq_pkg::*;
#(
    parameter int DATA_WIDTH    = 12,
    parameter int AVG_WINDOW    = 1024,
    parameter int SETTLE_CYCLES = 256,
    parameter int FRAME_LEN     = 256,
    parameter int DECIM         = 4
) (
    input  logic                         adc_clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         recal,
    input  logic                         dcr_en,
    input  logic signed [DATA_WIDTH:0]   dcr_data,
    output logic                         dcr_stable,
    output logic signed [DATA_WIDTH:0]   out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_last,
    output logic                         busy,
    output logic                         err,
    output logic                         overrun,
    output logic [2:0]                   state_o
);

    localparam int TIMEOUT   = calib_timeout(AVG_WINDOW);
    localparam int SETTLE_W  = cnt_width(SETTLE_CYCLES);
    localparam int TIMEOUT_W = cnt_width(TIMEOUT);
`ifdef DCR_SEQ_DECIM_EN
    localparam bit DECIM_ON = 1'b1;
`else
    localparam bit DECIM_ON = 1'b0;
`endif
    localparam int ACCEPT_EVERY = DECIM_ON ? DECIM : 1;
    localparam int PHASE_W      = cnt_width(ACCEPT_EVERY);

    dcr_state_t           state_reg;
    dcr_state_t           state_next;
    logic [SETTLE_W-1:0]  settle_cnt_reg;
    logic [TIMEOUT_W-1:0] timeout_cnt_reg;
    logic [PHASE_W-1:0]   phase_reg;
    logic                 dcr_en_prev_reg;
    logic                 en_rise;
    logic                 recal_ok;
    logic                 start_ok;
    logic                 flush;
    logic                 accept;

    assign en_rise  = dcr_en && !dcr_en_prev_reg;
    assign recal_ok = recal && !stop && (state_reg == RUN || state_reg == ERR);
    assign start_ok = start && !stop && (state_reg == IDLE);
    assign flush    = stop || recal_ok;
    assign accept   = (state_reg == RUN) && (phase_reg == '0) && !flush;

    always_comb begin
        state_next = state_reg;
        if (stop) begin
            state_next = IDLE;
        end else if (recal_ok || start_ok) begin
            state_next = SETTLE;
        end else begin
            case (state_reg)
                SETTLE: begin
                    if (settle_cnt_reg == SETTLE_W'(SETTLE_CYCLES - 1)) state_next = CALIB;
                end
                CALIB: begin
                    // An edge on the final timeout cycle still wins over the timeout.
                    if (en_rise) state_next = RUN;
                    else if (timeout_cnt_reg == TIMEOUT_W'(TIMEOUT - 1)) state_next = ERR;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge adc_clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            settle_cnt_reg  <= '0;
            timeout_cnt_reg <= '0;
            phase_reg       <= '0;
            dcr_en_prev_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            dcr_en_prev_reg <= dcr_en;

            settle_cnt_reg  <= (state_reg == SETTLE && state_next == SETTLE)
                               ? settle_cnt_reg + 1'b1 : '0;
            timeout_cnt_reg <= (state_reg == CALIB && state_next == CALIB)
                               ? timeout_cnt_reg + 1'b1 : '0;

            // Phase restarts at 0 on every entry to RUN, so the first RUN cycle is accepted.
            if (state_reg == RUN && state_next == RUN) begin
                phase_reg <= (phase_reg == PHASE_W'(ACCEPT_EVERY - 1)) ? '0 : phase_reg + 1'b1;
            end else begin
                phase_reg <= '0;
            end
        end
    end

    dcr_frame_out #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAME_LEN  (FRAME_LEN)
    ) u_frame_out (
        .clk       (adc_clk),
        .rst       (rst),
        .flush     (flush),
        .clr_ovr   (start_ok),
        .accept    (accept),
        .in_data   (dcr_data),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .overrun   (overrun)
    );

    assign dcr_stable = (state_reg == CALIB) || (state_reg == RUN);
    assign busy       = (state_reg != IDLE);
    assign err        = (state_reg == ERR);
    assign state_o    = state_reg;

endmodule
